// File: rtl/us_pulse_generator_if.sv
// us_pulse_generator_if: control/status bundle between a pulse-sequence requester and us_pulse_generator
//   start, abort, continuous     request / terminate / repeat controls (master -> slave)
//   pulse_width_us, period_us    pulse high time and rising-edge spacing in us (master -> slave)
//   pulse_out, busy, done        generated pulse, sequence active, normal-end strobe (slave -> master)
//   pulse_count                  rising edges since last accepted start (slave -> master)
interface us_pulse_generator_if #(parameter int CNT_W = 16);
    logic             start;
    logic             abort;
    logic             continuous;
    logic [CNT_W-1:0] pulse_width_us;
    logic [CNT_W-1:0] period_us;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_count;
    modport master(
        output start, abort, continuous, pulse_width_us, period_us,
        input  pulse_out, busy, done, pulse_count
    );
    modport slave(
        input  start, abort, continuous, pulse_width_us, period_us,
        output pulse_out, busy, done, pulse_count
    );
endinterface

// File: rtl/us_pulse_generator.sv
// us_pulse_generator: microsecond pulse transmitter with programmable width and period, one-shot or continuous
//   clk_1mhz  1 MHz timebase, one cycle = 1 us
//   reset     asynchronous active-high reset
//   bus       us_pulse_generator_if.slave: start/abort/continuous/width/period in, pulse_out/busy/done/pulse_count out
module us_pulse_generator #(
    parameter int CNT_W = 16
) (
    input  logic                    clk_1mhz,
    input  logic                    reset,
    us_pulse_generator_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    state_t           state_q, state_d;
    logic [CNT_W:0]   elapsed_q, elapsed_d;
    logic [CNT_W-1:0] w_q, w_d, p_q, p_d, count_q, count_d;
    logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
    logic [CNT_W:0]   pe;
    // Period is stretched to W+1 when too short so there is always a low cycle; one extra bit avoids overflow at max W.
    assign pe = (p_q > w_q) ? {1'b0, p_q} : {1'b0, w_q} + (CNT_W+1)'(1);
    always_comb begin
        state_d   = state_q;
        elapsed_d = elapsed_q;
        w_d       = w_q;
        p_d       = p_q;
        count_d   = count_q;
        pulse_d   = pulse_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.pulse_width_us != '0) begin
                        state_d   = PULSE;
                        w_d       = bus.pulse_width_us;
                        p_d       = bus.period_us;
                        elapsed_d = (CNT_W+1)'(1);
                        count_d   = CNT_W'(1);
                        pulse_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    elapsed_d = elapsed_q + (CNT_W+1)'(1);
                    if (elapsed_q == {1'b0, w_q}) begin
                        state_d = GAP;
                        pulse_d = 1'b0;
                    end
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (elapsed_q == pe) begin
                    if (bus.continuous) begin
                        state_d   = PULSE;
                        elapsed_d = (CNT_W+1)'(1);
                        pulse_d   = 1'b1;
                        count_d   = count_q + CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    elapsed_d = elapsed_q + (CNT_W+1)'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_1mhz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            elapsed_q <= '0;
            w_q       <= '0;
            p_q       <= '0;
            count_q   <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            w_q       <= w_d;
            p_q       <= p_d;
            count_q   <= count_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign bus.pulse_out   = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulse_count = count_q;
endmodule

// File: tb/tb_us_pulse_generator.sv
// tb_us_pulse_generator: scoreboard bench for us_pulse_generator against a period-arithmetic reference model
module tb_us_pulse_generator;
    localparam int CNT_W = 16;
    logic clk_1mhz = 1'b0;
    logic reset = 1'b1;
    us_pulse_generator_if #(.CNT_W(CNT_W)) bus();
    us_pulse_generator #(.CNT_W(CNT_W)) dut (.clk_1mhz(clk_1mhz), .reset(reset), .bus(bus));
    always #5 clk_1mhz = ~clk_1mhz;
    typedef struct packed {
        logic             pulse;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } obs_t;
    obs_t q[$];
    int vectors = 0;
    int errors = 0;
    bit m_act = 0;
    int m_s = 0, m_w = 0, m_pe = 1, m_edge = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got pulse=%b busy=%b done=%b cnt=%0d, want pulse=%b busy=%b done=%b cnt=%0d",
                     name, $time, act.pulse, act.busy, act.done, act.cnt, exp.pulse, exp.busy, exp.done, exp.cnt);
        end
    endtask
    always @(negedge clk_1mhz) begin
        obs_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("cycle", {bus.pulse_out, bus.busy, bus.done, bus.pulse_count}, e);
        end
    end
    // A sequence started at edge m_s is in cycle c = edge - m_s + 1; each period of Pe cycles is high for its first W.
    task automatic model();
        obs_t e;
        int c, p;
        bit d;
        d = 0;
        m_edge++;
        if (m_act) begin
            c = m_edge - m_s + 1;
            if (bus.abort) m_act = 0;
            else if (c > 1 && (c - 1) % m_pe == 0) begin
                if (bus.continuous) m_cnt++;
                else begin
                    m_act = 0;
                    d = 1;
                end
            end
        end else if (bus.start && !bus.abort) begin
            if (bus.pulse_width_us != 0) begin
                m_act = 1;
                m_s = m_edge;
                m_w = int'(bus.pulse_width_us);
                p = int'(bus.period_us);
                m_pe = (p > m_w) ? p : m_w + 1;
                m_cnt = 1;
            end else begin
                m_cnt = 0;
                d = 1;
            end
        end
        if (m_act) begin
            c = m_edge - m_s + 1;
            e.pulse = (((c - 1) % m_pe) + 1) <= m_w;
            e.busy = 1'b1;
        end else begin
            e.pulse = 1'b0;
            e.busy = 1'b0;
        end
        e.done = d;
        e.cnt = m_cnt;
        q.push_back(e);
    endtask
    task automatic cyc(input bit st, input bit ab, input bit co, input int w, input int p);
        bus.start = st;
        bus.abort = ab;
        bus.continuous = co;
        bus.pulse_width_us = CNT_W'(w);
        bus.period_us = CNT_W'(p);
        @(posedge clk_1mhz);
        model();
        @(negedge clk_1mhz);
    endtask
    task automatic idle(input int n, input bit co);
        for (int i = 0; i < n; i++) cyc(0, 0, co, 0, 0);
    endtask
    task automatic async_reset();
        reset = 1'b1;
        #1;
        check("async_reset", {bus.pulse_out, bus.busy, bus.done, bus.pulse_count}, '0);
        m_act = 0;
        m_cnt = '0;
        @(posedge clk_1mhz);
        @(negedge clk_1mhz);
        reset = 1'b0;
    endtask
    initial begin
        bit co;
        bus.start = 0;
        bus.abort = 0;
        bus.continuous = 0;
        bus.pulse_width_us = '0;
        bus.period_us = '0;
        repeat (2) @(negedge clk_1mhz);
        check("reset_state", {bus.pulse_out, bus.busy, bus.done, bus.pulse_count}, '0);
        reset = 1'b0;
        cyc(1, 0, 0, 10, 0);
        idle(13, 0);
        cyc(1, 0, 1, 10, 60);
        idle(100, 1);
        idle(30, 0);
        cyc(1, 0, 0, 5, 20);
        idle(1, 0);
        cyc(1, 0, 0, 50, 20);
        idle(25, 0);
        cyc(1, 0, 0, 0, 0);
        idle(3, 0);
        cyc(1, 0, 0, 100, 0);
        idle(38, 0);
        cyc(0, 1, 0, 0, 0);
        idle(3, 0);
        cyc(1, 1, 0, 10, 0);
        idle(3, 0);
        cyc(1, 0, 0, 10, 0);
        idle(3, 0);
        async_reset();
        cyc(1, 0, 1, 3, 3);
        idle(8, 1);
        idle(8, 0);
        cyc(1, 0, 0, 4, 5);
        idle(8, 0);
        cyc(1, 0, 0, 6, 2);
        idle(9, 0);
        cyc(1, 0, 1, 1, 0);
        idle(7, 1);
        idle(4, 0);
        co = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) co = ~co;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0, co,
                int'($urandom_range(0, 12)), int'($urandom_range(0, 25)));
        end
        idle(2, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk_1mhz);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
